// File: rtl/mul_seq_pkg.sv
// mul_pkg: shared constants and types for the sequential multiplier.
//   MUL_WIDTH - default operand width (product is 2*MUL_WIDTH bits)
//   CNT_W     - step counter width for MUL_WIDTH
//   state_t   - FSM state encoding
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int CNT_W     = $clog2(MUL_WIDTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: operand/result bundle of the sequential multiplier.
//   a, b, sign, start : request side (master drives)
//   hi, lo, busy, done: result/status side (slave drives)
interface mul_seq_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) ();

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sign;
   logic             start;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output a, b, sign, start,
      input  hi, lo, busy, done
   );

   modport slave (
      input  a, b, sign, start,
      output hi, lo, busy, done
   );

endinterface

// File: rtl/mul_seq_step.sv
// mul_step: one combinational radix-2 shift-add iteration.
//   acc_hi     - upper half of the accumulator
//   acc_lo     - accumulator bits [WIDTH-1:1] (bit 0 is always zero before a step)
//   mcand      - multiplicand magnitude
//   mplier     - remaining multiplier bits (LSB selects the add)
//   acc_nxt    - accumulator after add and right shift (carry shifted in)
//   mplier_nxt - multiplier shifted right by one
module mul_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   acc_hi,
   input  logic [WIDTH-2:0]   acc_lo,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0]   mplier_nxt
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum        = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};
      // {carry, acc} >> 1: the vacated low bit 0 simply drops out
      acc_nxt    = {sum, acc_lo};
      mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
   end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiplier (MULT/MULTU).
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mul_seq_if.slave: a, b, sign, start in; hi, lo, busy, done out
// Operands are converted to magnitudes on accept, multiplied unsigned over
// WIDTH steps, and the sign is restored on the final step.
// Build option: MUL_SEQ_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits are all zero (results unchanged, latency 1..WIDTH).
module mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic      clk,
   input  logic      rst,
   mul_seq_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   // Bit 0 of the accumulator is never nonzero between steps, so it is not stored
   logic [2*WIDTH-1:1] acc_q;
   logic [CW-1:0]      count;
   logic               neg;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               finish;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] result;

   mul_step #(.WIDTH(WIDTH)) u_step (
      .acc_hi     (acc_q[2*WIDTH-1:WIDTH]),
      .acc_lo     (acc_q[WIDTH-1:1]),
      .mcand      (mcand),
      .mplier     (mplier),
      .acc_nxt    (acc_nxt),
      .mplier_nxt (mplier_nxt)
   );

   always_comb begin
      a_mag = (bus.sign && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
      b_mag = (bus.sign && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
`ifdef MUL_SEQ_EARLY_TERM_EN
      // Skip the remaining all-zero multiplier steps with one variable shift
      finish = (count == CW'(WIDTH-1)) || (mplier_nxt == '0);
      prod   = acc_nxt >> (CW'(WIDTH-1) - count);
`else
      finish = (count == CW'(WIDTH-1));
      prod   = acc_nxt;
`endif
      result = neg ? ('0 - prod) : prod;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc_q  <= '0;
         count  <= '0;
         neg    <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  acc_q  <= '0;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q  <= acc_nxt[2*WIDTH-1:1];
               mplier <= mplier_nxt;
               count  <= count + 1'b1;
               if (finish) begin
                  {hi_q, lo_q} <= result;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq.
// Honours MUL_SEQ_EARLY_TERM_EN when computing expected latency.
module tb_mul_seq;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic [63:0] last_res;

   mul_seq_if #(.WIDTH(32)) bus ();

   mul_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef MUL_SEQ_EARLY_TERM_EN
      logic [31:0] m;
      int h;
      m = (s && b[31]) ? (32'd0 - b) : b;
      h = -1;
      for (int i = 0; i < 32; i++) if (m[i]) h = i;
      return (h < 0) ? 1 : h + 1;
`else
      return (b === 32'hx && s === 1'bx) ? 0 : 32;
`endif
   endfunction

   // Called #1 after a rising edge. Checks accept, hold of previous result,
   // busy during run, latency, product and done width.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [63:0] exp);
      int n;
      bit seen;
      bus.a = ta; bus.b = tb_v; bus.sign = ts; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_accept_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_hold"}, {bus.hi, bus.lo}, last_res);
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (bus.done) seen = 1;
         else if (!bus.busy) begin
            check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
         end
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_lat(tb_v, ts)));
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, "_prod"}, {bus.hi, bus.lo}, exp);
      last_res = exp;
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int n, k, lat, dones;
      bit seen;
      tests = 0; fails = 0; last_res = 64'd0;
      rst = 1'b0;
      bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0;
      #2;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_op("u3x5",      32'd3,          32'd5,          1'b0, 64'h00000000_0000000F);
      run_op("sm3x5",     32'hFFFFFFFD,   32'd5,          1'b1, 64'hFFFFFFFF_FFFFFFF1);
      run_op("u_ffxff",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001);
      run_op("s_ffxff",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h00000000_00000001);
      run_op("s_minxmin", 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000);
      run_op("s_minx1",   32'h80000000,   32'd1,          1'b1, 64'hFFFFFFFF_80000000);

      // 7*9 with an ignored start pulse and operand changes mid-run
      lat = exp_lat(32'd9, 1'b0);
      k = (lat > 10) ? 10 : lat - 1;
      bus.a = 32'd7; bus.b = 32'd9; bus.sign = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0; seen = 0; dones = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (bus.done) begin seen = 1; dones++; end
         bus.start = (n == k);
         if (n == k) begin
            bus.a = 32'd2; bus.b = 32'd2; bus.sign = 1'b1;
         end else if (n == k + 1) begin
            bus.a = 32'h1234_5678; bus.b = 32'hDEAD_BEEF;
         end
      end
      check("ign_latency", 64'(n), 64'(lat));
      check("ign_prod", {bus.hi, bus.lo}, 64'd63);
      check("ign_single_done", 64'(dones), 64'd1);
      last_res = 64'd63;
      // Back-to-back: start presented in the done cycle
      bus.a = 32'd6; bus.b = 32'd7; bus.sign = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b_accept_busy", 64'(bus.busy), 64'd1);
      check("b2b_done_low", 64'(bus.done), 64'd0);
      check("b2b_hold", {bus.hi, bus.lo}, last_res);
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (bus.done) seen = 1;
      end
      check("b2b_latency", 64'(n), 64'(exp_lat(32'd7, 1'b0)));
      check("b2b_prod", {bus.hi, bus.lo}, 64'd42);
      last_res = 64'd42;
      @(posedge clk); #1;

      run_op("u6x0", 32'd6, 32'd0, 1'b0, 64'd0);
      run_op("u5x1", 32'd5, 32'd1, 1'b0, 64'd5);

      // Asynchronous reset in the middle of a run
      bus.a = 32'd3; bus.b = 32'h8000_0007; bus.sign = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_idle", 64'(bus.busy), 64'd0);
      last_res = 64'd0;

      run_op("post_reset", 32'd1000, 32'd1000, 1'b0, 64'd1000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier for the MIPS datapath (MULT/MULTU); the multiplicative counterpart of the sequential divider.
- Accepts two 32-bit operands on a start pulse and works for WIDTH cycles with busy asserted.
- Delivers a registered 64-bit product split into hi/lo, for the HI/LO register file.
- Uses the same start/busy handshake as the divider, plus a one-cycle done strobe.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- a  input  WIDTH  multiplicand; sampled only on accepted start.
- b  input  WIDTH  multiplier; sampled only on accepted start.
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled on accepted start.
- start  input  1  request; accepted when start=1 and busy=0 at a clock edge.
- hi  output  WIDTH  upper half of product, registered.
- lo  output  WIDTH  lower half of product, registered.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo just updated.

Behaviour:
- Reset (rst=0, asynchronous): busy=0, done=0, hi=0, lo=0, count=0, internal accumulators cleared. An operation in progress is aborted and no done is produced.
- States: IDLE, RUN.
- IDLE -> RUN on accept edge E:
  - Latch |a| and |b| when sign=1 and the operand MSB is set; otherwise latch raw values.
  - Latch neg = sign & (a[W-1] ^ b[W-1]).
  - Clear the 2W-bit accumulator; count=0; busy=1.
- RUN, one step per edge:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator (W+1-bit add, carry kept).
  - Shift the {carry, accumulator} right by 1; shift the multiplier right by 1; count+1.
- Last step (count==WIDTH-1) at edge E+WIDTH:
  - {hi,lo} = neg ? two's-complement negation of the final accumulator : final accumulator.
  - busy=0, done=1 for exactly one cycle; return to IDLE.
- Latency: result visible after edge E+WIDTH, i.e. 32 cycles for WIDTH=32.
- Throughput: a new start may be accepted on the edge immediately after done.
- hi/lo hold their value until the next completion. They are not cleared on start.
- start while busy=1 is ignored: no restart, no queueing.
- Operand or sign changes during RUN have no effect.
- Magnitude of -2^(W-1) is 2^(W-1) and fits in W unsigned bits; no overflow case exists.
- Signed 0xFFFFFFFF*0xFFFFFFFF must give +1 (hi=0, lo=1).
- done and busy are never both 1.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- Defined:
  - In RUN, when the remaining (already shifted) multiplier bits are all zero, the block finishes on that edge.
  - The accumulator is shifted right by the remaining WIDTH-count positions in one step, and sign correction is applied.
  - busy falls and done pulses on that edge.
  - Minimum latency is 1 cycle (b=0); maximum stays WIDTH.
- Undefined: fixed WIDTH-cycle latency as above.
- Results are identical in both builds.

Decomposition:
- Package mul_pkg:
  - MUL_WIDTH=32.
  - State enum {ST_IDLE, ST_RUN}.
  - Counter width constant CNT_W=$clog2(MUL_WIDTH).
- Sub-module mul_step: combinational one-iteration datapath.
  - Inputs: accumulator upper half, multiplicand, multiplier LSB.
  - Outputs: next accumulator and next multiplier.
  - Instantiated once.
- The sign/negate logic and FSM stay in mul_seq.

Test Plan:
- Unsigned 3*5 (sign=0) -> after 32 cycles done=1, hi=0x00000000, lo=0x0000000F; busy high for exactly 32 cycles.
- Signed -3*5 (a=0xFFFFFFFD, b=5, sign=1) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- a=b=0xFFFFFFFF: sign=0 -> hi=0xFFFFFFFE, lo=0x00000001; sign=1 -> hi=0, lo=1.
- Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000. Signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start 7*9, pulse start with 2*2 at cycle 10 and change a/b mid-run -> result 63 (lo=0x3F), single done; then back-to-back start on the cycle after done accepted.
- Start, drive rst=0 at cycle 12 -> busy=0, hi=lo=0 immediately; no done. With MUL_SEQ_EARLY_TERM_EN, 6*0 completes in 1 cycle and 5*1 completes in 1 cycle, with correct products.
